// File: rtl/regbank1024_n.sv
// regbank1024_n
//   A 1024-entry register bank of n-bit words. Every entry is driven out in
//   parallel on data_o, which feeds a 1024:1 read mux organised as 32 x 32.
//   The bank has one write port and a bulk-clear sequencer. The sequencer
//   zeroes one 32-entry group per clock, so a full sweep takes 32 edges.
//
//   Ports
//     clk_i     clock; all state updates on the rising edge
//     rst_i     asynchronous active-high reset
//     we_i      write request (single-cycle, see handshake note below)
//     waddr_i   write address
//     wdata_i   write data
//     clr_i     bulk-clear request (level-sampled in IDLE)
//     data_o    registered contents of every entry
//     busy_o    high while the clear sweep runs (this is the FSM state)
//     done_o    one-cycle pulse after the edge that clears the last group
//     wr_rej_o  one-cycle pulse: the write presented on the previous edge
//               was dropped because a sweep was running
//
//   Handshake: there is no ready signal. A write is offered by holding we_i
//   high across exactly one rising edge. It is accepted if the bank is IDLE
//   at that edge. Otherwise it is discarded, and wr_rej_o reports the drop
//   for the following cycle. Each dropped request produces its own pulse, so
//   back-to-back drops keep wr_rej_o high.
module regbank1024_n #(
  parameter int n       = 4,
  parameter int address = 10,
  parameter int gr      = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [address-1:0] waddr_i,
  input  logic [n-1:0]       wdata_i,
  input  logic               clr_i,
  output logic [n-1:0]       data_o [0:2**address-1],
  output logic               busy_o,
  output logic               done_o,
  output logic               wr_rej_o
);

  localparam int depth    = 2**address;
  localparam int grp_size = depth / gr;
  localparam int cw       = $clog2(gr);
  localparam logic [cw-1:0] last_grp = cw'(gr - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [cw-1:0] grp_q, grp_d;
  logic          done_d;
  logic          wr_ok;
  logic          clearing;

  // Next-state logic. In IDLE, the group counter is always held at zero.
  // It only advances while a sweep runs.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          grp_d   = '0;
        end
      end
      CLEAR: begin
        // clr_i is deliberately ignored here: a sweep is never extended.
        if (grp_q == last_grp) begin
          state_d = IDLE;
          grp_d   = '0;
          done_d  = 1'b1;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grp_d   = '0;
      end
    endcase
  end

  assign wr_ok    = we_i && (state_q == IDLE);
  assign clearing = (state_q == CLEAR);

  // busy_o is a straight decode of the state flop, so it is glitch-free.
  // It also exposes the FSM state directly.
  assign busy_o = clearing;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grp_q    <= '0;
      done_o   <= 1'b0;
      wr_rej_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      done_o   <= done_d;
      wr_rej_o <= we_i && clearing;
    end
  end

  // Storage. A write and the first clear edge never target the same cycle:
  // the write happens in IDLE, and clearing starts on the edge after that.
  // So a write issued alongside clr_i lands first. Its group's clear later
  // zeroes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < depth; i++) begin
        data_o[i] <= '0;
      end
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (clearing && (grp_q == cw'(i / grp_size))) begin
          data_o[i] <= '0;
        end else if (wr_ok && (waddr_i == address'(i))) begin
          data_o[i] <= wdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_regbank1024_n.sv
module tb_regbank1024_n;

  localparam int N     = 4;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int GRP   = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic          clr;
  logic [N-1:0]  data_o [0:DEPTH-1];
  logic          busy_o;
  logic          done_o;
  logic          wr_rej_o;

  regbank1024_n #(.n(N), .address(AW), .gr(GRP)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .clr_i   (clr),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .wr_rej_o(wr_rej_o)
  );

  // scoreboard
  logic [N-1:0] exp_mem [0:DEPTH-1];
  logic [N-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int sweep_k;
  int early_done;
  int busy_cnt;
  int guard;
  logic busy_log [1:70];
  logic done_log [1:70];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_bad();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (data_o[i] !== exp_mem[i]) bad++;
    end
    return bad;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input logic [N-1:0] d);
    we    = 1'b1;
    waddr = AW'(a);
    wdata = d;
    tick();
    we = 1'b0;
    exp_mem[a] = d;
  endtask

  // One edge of a sweep: after it, group sweep_k of the model is zero.
  task automatic sweep_edge();
    tick();
    if (sweep_k < GRP) begin
      for (int j = 0; j < GRP; j++) exp_mem[sweep_k * GRP + j] = '0;
    end
    if (done_o && (sweep_k != GRP - 1)) early_done++;
    sweep_k++;
  endtask

  task automatic start_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sweep_k    = 0;
    early_done = 0;
  endtask

  initial begin
    we = 1'b0; waddr = '0; wdata = '0; clr = 1'b0;
    clear_model();

    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst_bank", count_bad(), 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rej", wr_rej_o, 0);
    tick(); tick();
    #2 rst = 1'b0;
    tick();

    // readback with one-edge latency
    exp_q.push_back(4'hA); write(5, 4'hA);
    check("wr_5", data_o[5], exp_q.pop_front());
    check("wr_5_bank", count_bad(), 0);
    exp_q.push_back(4'h3); write(1023, 4'h3);
    check("wr_1023", data_o[1023], exp_q.pop_front());
    check("wr_1023_bank", count_bad(), 0);
    exp_q.push_back(4'hF); write(0, 4'hF);
    check("wr_0", data_o[0], exp_q.pop_front());
    check("wr_0_bank", count_bad(), 0);

    // asynchronous reset mid-cycle
    rst = 1'b1;
    #1;
    clear_model();
    check("async_rst_bank", count_bad(), 0);
    check("async_rst_busy", busy_o, 0);
    #1 rst = 1'b0;
    tick();

    // clear timing on a full bank
    for (int a = 0; a < DEPTH; a++) write(a, 4'h5);
    check("fill_bank", count_bad(), 0);
    start_clear();
    busy_cnt = 0;
    for (int k = 1; k <= GRP; k++) begin
      if (busy_o) busy_cnt++;
      sweep_edge();
      if (k == 1) begin
        check("sweep1_e31", data_o[31], 0);
        check("sweep1_e32", data_o[32], 5);
        check("sweep1_bank", count_bad(), 0);
      end
    end
    check("clr_busy_len", busy_cnt, 32);
    check("clr_busy_end", busy_o, 0);
    check("clr_done", done_o, 1);
    check("clr_early_done", early_done, 0);
    check("clr_bank", count_bad(), 0);
    tick();
    check("clr_done_pulse", done_o, 0);

    // write lockout, including back-to-back rejects
    for (int a = 0; a < DEPTH; a++) write(a, 4'h5);
    start_clear();
    for (int k = 1; k <= GRP; k++) begin
      if (k == 10) begin we = 1'b1; waddr = AW'(1000); wdata = 4'h7; end
      if (k == 20) begin we = 1'b1; waddr = AW'(900);  wdata = 4'hE; end
      if (k == 21) begin we = 1'b1; waddr = AW'(901);  wdata = 4'hE; end
      sweep_edge();
      we = 1'b0;
      if (k == 10) begin
        check("lock_rej", wr_rej_o, 1);
        check("lock_1000", data_o[1000], 5);
        check("lock_bank", count_bad(), 0);
      end
      if (k == 11) check("lock_rej_clr", wr_rej_o, 0);
      if (k == 20) check("lock_rej_b2b0", wr_rej_o, 1);
      if (k == 21) check("lock_rej_b2b1", wr_rej_o, 1);
      if (k == 22) check("lock_rej_b2b_end", wr_rej_o, 0);
      if (k == 31) check("lock_1000_late", data_o[1000], 5);
    end
    check("lock_1000_final", data_o[1000], 0);
    check("lock_done", done_o, 1);
    check("lock_early_done", early_done, 0);
    check("lock_final_bank", count_bad(), 0);

    // simultaneous write and clear
    tick();
    we = 1'b1; waddr = AW'(40); wdata = 4'h9; clr = 1'b1;
    tick();
    we = 1'b0; clr = 1'b0;
    exp_mem[40] = 4'h9;
    sweep_k = 0; early_done = 0;
    check("sim_wr", data_o[40], 9);
    check("sim_busy", busy_o, 1);
    for (int k = 1; k <= GRP; k++) begin
      sweep_edge();
      if (k == 1) check("sim_e1", data_o[40], 9);
      if (k == 2) check("sim_e2", data_o[40], 0);
    end
    check("sim_done", done_o, 1);
    check("sim_early_done", early_done, 0);
    check("sim_bank", count_bad(), 0);

    // reset in the middle of a sweep
    tick();
    write(1000, 4'hC);
    write(600, 4'h6);
    start_clear();
    for (int k = 1; k <= 14; k++) sweep_edge();
    check("mid_early_done", early_done, 0);
    rst = 1'b1;
    #1;
    clear_model();
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_bank", count_bad(), 0);
    check("mid_rst_done", done_o, 0);
    #1 rst = 1'b0;
    guard = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done_o || busy_o) guard++;
    end
    check("mid_rst_quiet", guard, 0);
    start_clear();
    busy_cnt = 0;
    guard = 0;
    while (busy_o && guard < 40) begin
      busy_cnt++;
      guard++;
      sweep_edge();
    end
    check("mid_new_busy_len", busy_cnt, 32);
    check("mid_new_done", done_o, 1);

    // clr_i held high for 70 cycles
    tick();
    write(77, 4'h3);
    clr = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      busy_log[i] = busy_o;
      done_log[i] = done_o;
    end
    clr = 1'b0;
    busy_cnt = 0;
    guard = 0;
    for (int i = 1; i <= 70; i++) begin
      if (!busy_log[i]) busy_cnt++;
      if (done_log[i]) guard++;
    end
    check("held_busy_first", busy_log[1], 1);
    check("held_gap1", busy_log[33], 0);
    check("held_resume1", busy_log[34], 1);
    check("held_gap2", busy_log[66], 0);
    check("held_resume2", busy_log[67], 1);
    check("held_low_cycles", busy_cnt, 2);
    check("held_done1", done_log[33], 1);
    check("held_done2", done_log[66], 1);
    check("held_done_cnt", guard, 2);
    guard = 0;
    while (!done_o && guard < 40) begin
      tick();
      guard++;
    end
    check("held_tail_done", done_o, 1);
    clear_model();
    check("held_bank", count_bad(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank1024_n.md
Name: regbank1024_n

Overview:
- 1024-entry, n-bit register bank that drives the full 1024-entry data array into the 1024:1 read mux stage.
- Single write port.
- Bulk-clear sequencer zeroes the bank one 32-entry group per cycle, which matches the mux's 32 x 32 grouping.
- While a clear is running, writes are locked out and rejected with a flag.

Parameters:
- n, 4, data width of each entry
- address, 10, address width; depth = 2**address = 1024 (fixed for this block)
- gr, 32, number of groups cleared in a full sweep (= 2**address/32)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- we_i  in  1  write request
- waddr_i  in  address  write address
- wdata_i  in  n  write data
- clr_i  in  1  bulk-clear request
- data_o  out  n x 1024 (unpacked [0:2**address-1])  registered contents of every entry; feeds the read mux
- busy_o  out  1  high while the clear sweep is in progress
- done_o  out  1  one-cycle pulse when the clear sweep completes
- wr_rej_o  out  1  one-cycle pulse: the previous cycle's write was dropped

Behaviour:
- Reset (async, rst_i=1):
  - All 1024 entries = 0.
  - busy_o = 0, done_o = 0, wr_rej_o = 0.
  - Group counter = 0; FSM = IDLE.
  - Takes effect immediately, including in the middle of a sweep; the sweep is abandoned.
- FSM states: IDLE, CLEAR.
  - IDLE --clr_i=1--> CLEAR.
  - CLEAR --counter==31--> IDLE.
- busy_o is a registered output and equals (state==CLEAR).
- Write path (IDLE only):
  - When we_i=1 at edge t, entry[waddr_i] <= wdata_i.
  - The new value is visible on data_o after edge t (one-edge latency, no bypass).
  - No other entry changes.
- Clear sweep:
  - clr_i sampled high in IDLE at edge t: state <= CLEAR, counter <= 0, busy_o=1 from t.
  - At each edge in CLEAR, entries [32*counter .. 32*counter+31] are set to 0, then counter increments.
  - Sweep length is exactly 32 edges.
  - On the edge that clears group 31: state <= IDLE, busy_o <= 0, done_o <= 1 for one cycle, counter <= 0.
- Simultaneous write and clear in IDLE (we_i=1 and clr_i=1 at the same edge): the write is performed, and the sweep starts at that edge. The written entry is later zeroed by its group's clear, so after done_o the whole bank is 0.
- Write during CLEAR (we_i=1 while busy_o=1):
  - No entry changes.
  - wr_rej_o=1 for one cycle after that edge.
  - Each rejected request produces its own pulse; back-to-back rejects keep wr_rej_o high continuously.
- clr_i during CLEAR: ignored; the sweep is not restarted or extended.
- clr_i=1 held continuously: a new sweep starts on the first IDLE edge after done_o. busy_o is then low for exactly one cycle between sweeps.
- Address range: waddr_i covers 0..1023 fully; there is no out-of-range case.
- done_o and wr_rej_o are 0 on every cycle not described above.

Test Plan:
- Reset/readback: assert rst_i mid-cycle -> data_o all 0, busy_o=0 immediately. Write 0xA to 5, 0x3 to 1023, 0xF to 0 -> after each edge, data_o[5]=0xA, data_o[1023]=0x3, data_o[0]=0xF; all other entries 0.
- Clear timing: fill all 1024 entries with 0x5, pulse clr_i one cycle.
  - busy_o high for exactly 32 cycles.
  - After the 1st sweep edge, data_o[0..31]=0 and data_o[32]=0x5.
  - After the 32nd edge, all entries are 0 and done_o=1 for one cycle.
- Write lockout: start a clear, then on sweep cycle 10 write 0x7 to 1000 -> wr_rej_o=1 for one cycle; data_o[1000] stays 0x5 until group 31 clears it to 0; no other side effect.
- Simultaneous: in IDLE, we_i=1 (addr 40, 0x9) with clr_i=1 -> data_o[40]=0x9 after edge 0, 0 after sweep edge 2; done_o after 32 edges.
- Reset mid-sweep: assert rst_i at sweep cycle 15 -> busy_o=0, all entries 0, no done_o pulse. A new clr_i afterwards runs a full 32-cycle sweep.
- Held clr_i: hold clr_i=1 for 70 cycles -> two complete sweeps, with busy_o low for exactly one cycle between them and two done_o pulses.
